// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, width encodings and helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  // Byte offset actually used for lanes: bits below the access size are dropped.
  function automatic logic [1:0] eff_offset(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      W_BYTE:  return addr_lo;
      W_HALF:  return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      W_BYTE:  return 1'b0;
      W_HALF:  return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - data memory req/gnt/rvalid port bundle
interface lsu_mem_port_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane enables, store data replication and load extraction/extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_width,
  input  logic        i_unsigned,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_width)
      W_BYTE: begin
        o_be        = 4'b0001 << i_off;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = i_unsigned ? {24'b0, w_shifted[7:0]}
                                 : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      W_HALF: begin
        o_be        = 4'b0011 << i_off;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = i_unsigned ? {16'b0, w_shifted[15:0]}
                                 : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit issuing one access at a time to data memory
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_mem_read,
  input  logic           i_mem_write,
  input  logic [1:0]     i_mem_width,
  input  logic           i_load_unsigned,
  input  logic [31:0]    i_addr,
  input  logic [31:0]    i_store_data,
  output logic           o_busy,
  output logic           o_done,
  output logic [31:0]    o_load_data,
  output logic           o_err,
  output logic           o_misaligned,
  lsu_mem_port_if.master dmem
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [1:0]  r_off;
  logic [1:0]  r_width;
  logic        r_unsigned;
  logic [31:0] r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_misal;
  logic [31:0] r_load_data;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [3:0]  r_dmem_be;
  logic [31:0] r_dmem_wdata;

  logic        w_accept;
  logic        w_trap;
  logic        w_tmo;
  logic        w_capture;
  logic        w_tmo_hit;
  logic        w_misal_in;
  logic [1:0]  w_off_in;
  logic [1:0]  w_al_off;
  logic [1:0]  w_al_width;
  logic        w_al_unsigned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misal_in = is_misaligned(i_mem_width, i_addr[1:0]);
`else
  assign w_misal_in = 1'b0;
`endif

  assign w_off_in  = eff_offset(i_mem_width, i_addr[1:0]);
  assign w_tmo_hit = (TIMEOUT != 0) && (r_cnt >= TIMEOUT - 32'd1);

  // In IDLE the aligner sees the incoming request so lanes register on entry to REQ;
  // afterwards it sees the latched access for load extraction.
  assign w_al_off      = (r_state == ST_IDLE) ? w_off_in        : r_off;
  assign w_al_width    = (r_state == ST_IDLE) ? i_mem_width     : r_width;
  assign w_al_unsigned = (r_state == ST_IDLE) ? i_load_unsigned : r_unsigned;

  lsu_lane_align u_align (
    .i_off        (w_al_off),
    .i_width      (w_al_width),
    .i_unsigned   (w_al_unsigned),
    .i_store_data (i_store_data),
    .i_rdata      (dmem.dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_ext)
  );

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_trap    = 1'b0;
    w_tmo     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && (i_mem_read || i_mem_write)) begin
          if (w_misal_in) begin
            w_next = ST_DONE;
            w_trap = 1'b1;
          end else begin
            w_next   = ST_REQ;
            w_accept = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (dmem.dmem_gnt) begin
          w_next = r_dmem_we ? ST_DONE : ST_WAIT;
        end else if (w_tmo_hit) begin
          w_next = ST_DONE;
          w_tmo  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_rvalid) begin
          w_next    = ST_DONE;
          w_capture = 1'b1;
        end else if (w_tmo_hit) begin
          w_next = ST_DONE;
          w_tmo  = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_off        <= 2'b00;
      r_width      <= W_BYTE;
      r_unsigned   <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_misal      <= 1'b0;
      r_load_data  <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= 4'b0000;
      r_dmem_wdata <= '0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= (w_next == ST_DONE);
      r_dmem_req <= (w_next == ST_REQ);
      r_err      <= w_tmo;
      r_misal    <= w_trap;
      if (w_accept) begin
        r_cnt        <= '0;
        r_off        <= w_off_in;
        r_width      <= i_mem_width;
        r_unsigned   <= i_load_unsigned;
        r_dmem_we    <= i_mem_write;
        r_dmem_addr  <= {i_addr[31:2], 2'b00};
        r_dmem_be    <= w_be;
        r_dmem_wdata <= w_wdata;
      end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_capture) begin
        r_load_data <= w_ext;
      end else if (w_tmo || w_trap) begin
        r_load_data <= '0;
      end
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_load_data     = r_load_data;
  assign o_err           = r_err;
  assign o_misaligned    = r_misal;
  assign dmem.dmem_req   = r_dmem_req;
  assign dmem.dmem_we    = r_dmem_we;
  assign dmem.dmem_addr  = r_dmem_addr;
  assign dmem.dmem_be    = r_dmem_be;
  assign dmem.dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - scoreboard bench for lsu_mem_port
module tb_lsu_mem_port;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  mem_width;
  logic [31:0] addr, store_data;
  logic        busy_a, done_a, err_a, misal_a;
  logic [31:0] ldata_a;
  logic        busy_b, done_b, err_b, misal_b;
  logic [31:0] ldata_b;

  lsu_mem_port_if mem_if ();
  lsu_mem_port_if tmo_if ();

  lsu_mem_port u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_mem_width(mem_width), .i_load_unsigned(load_unsigned), .i_addr(addr), .i_store_data(store_data),
    .o_busy(busy_a), .o_done(done_a), .o_load_data(ldata_a), .o_err(err_a), .o_misaligned(misal_a),
    .dmem(mem_if)
  );

  lsu_mem_port #(.TIMEOUT(4)) u_dut_tmo (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_mem_width(mem_width), .i_load_unsigned(load_unsigned), .i_addr(addr), .i_store_data(store_data),
    .o_busy(busy_b), .o_done(done_b), .o_load_data(ldata_b), .o_err(err_b), .o_misaligned(misal_b),
    .dmem(tmo_if)
  );

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        req;
    logic [31:0] ldata;
    logic        err;
    logic        misal;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_grant = 0;
  int          done_cnt = 0;
  int          start_cyc = 0;
  int          grant_base = 0;
  logic [31:0] model_ldata = 0;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_be(input logic [1:0] w, input logic [31:0] a);
    case (w)
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] sd);
    case (w)
      2'b00:   return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      2'b01:   return {sd[15:0], sd[15:0]};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] w, input logic uns, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a[1:0] +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (w)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_if.dmem_req && mem_if.dmem_gnt) begin
      obs_addr  <= mem_if.dmem_addr;
      obs_be    <= mem_if.dmem_be;
      obs_wdata <= mem_if.dmem_wdata;
      obs_we    <= mem_if.dmem_we;
      n_grant   <= n_grant + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done_a) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", {31'b0, done_a}, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq({e.tag, "_latency"}, cyc - start_cyc, e.lat);
        check_eq({e.tag, "_grants"}, n_grant - grant_base, {31'b0, e.req});
        check_eq({e.tag, "_ldata"}, ldata_a, e.ldata);
        check_eq({e.tag, "_err"}, {31'b0, err_a}, {31'b0, e.err});
        check_eq({e.tag, "_misal"}, {31'b0, misal_a}, {31'b0, e.misal});
        if (e.req) begin
          check_eq({e.tag, "_addr"}, obs_addr, e.addr);
          check_eq({e.tag, "_we"}, {31'b0, obs_we}, {31'b0, e.we});
          if (e.we) begin
            check_eq({e.tag, "_be"}, {28'b0, obs_be}, {28'b0, e.be});
            check_eq({e.tag, "_wdata"}, obs_wdata, e.wdata);
          end
        end
        done_cnt <= done_cnt + 1;
      end
    end
  end

  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [1:0] w,
                            input logic uns, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int gdly, input int rdly,
                            input logic [3:0] xbe, input logic [31:0] xwd, input logic [31:0] xld);
    exp_t e;
    int   base, k, since;
    bit   g, is_load;
    is_load = !wr;
    e.tag   = tag;
    e.addr  = {a[31:2], 2'b00};
    e.be    = xbe;
    e.wdata = xwd;
    e.we    = wr;
    e.req   = 1'b1;
    e.err   = 1'b0;
    e.misal = 1'b0;
    e.ldata = is_load ? xld : model_ldata;
    e.lat   = is_load ? gdly + rdly + 2 : gdly + 2;
    model_ldata = e.ldata;
    @(negedge clk); #1;
    check_eq({tag, "_idle"}, {31'b0, busy_a}, 0);
    mem_read = rd; mem_write = wr; mem_width = w; load_unsigned = uns;
    addr = a; store_data = sd; start_a = 1'b1;
    sb_q.push_back(e);
    start_cyc = cyc; grant_base = n_grant; base = done_cnt;
    @(negedge clk); #1;
    start_a = 1'b0; addr = $urandom; store_data = $urandom;
    mem_width = 2'($urandom); load_unsigned = ~uns;
    check_eq({tag, "_busy"}, {31'b0, busy_a}, 1);
    g = 0; since = 0; k = 0;
    while (done_cnt == base && k < 40) begin
      mem_if.dmem_gnt = 1'b0; mem_if.dmem_rvalid = 1'b0; mem_if.dmem_rdata = $urandom;
      start_a = (k == 0); mem_read = 1'b1; mem_write = (k == 0);
      if (!g) begin
        check_eq({tag, "_req_held"}, {31'b0, mem_if.dmem_req}, 1);
        if (k >= gdly) begin
          mem_if.dmem_gnt = 1'b1; g = 1;
        end else begin
          mem_if.dmem_rvalid = 1'b1;
        end
      end else begin
        since++;
        check_eq({tag, "_req_drop"}, {31'b0, mem_if.dmem_req}, 0);
        if (is_load && since == rdly) begin
          mem_if.dmem_rvalid = 1'b1; mem_if.dmem_rdata = rdata;
        end
      end
      @(negedge clk); #1; k++;
    end
    start_a = 1'b0; mem_if.dmem_gnt = 1'b0; mem_if.dmem_rvalid = 1'b0;
    check_eq({tag, "_done_seen"}, done_cnt - base, 1);
    if (done_cnt == base) sb_q.delete();
    else check_eq({tag, "_busy_in_done"}, {31'b0, busy_a}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op, w;
    logic [31:0] a, sd, rdv;
    logic        uns;
    int          base;
    rst = 1'b1; start_a = 0; start_b = 0; mem_read = 0; mem_write = 0; mem_width = 0;
    load_unsigned = 0; addr = 0; store_data = 0;
    mem_if.dmem_gnt = 0; mem_if.dmem_rvalid = 0; mem_if.dmem_rdata = 0;
    tmo_if.dmem_gnt = 0; tmo_if.dmem_rvalid = 0; tmo_if.dmem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", {31'b0, busy_a}, 0);
    check_eq("rst_done", {31'b0, done_a}, 0);
    check_eq("rst_err", {31'b0, err_a}, 0);
    check_eq("rst_misal", {31'b0, misal_a}, 0);
    check_eq("rst_req", {31'b0, mem_if.dmem_req}, 0);
    check_eq("rst_we", {31'b0, mem_if.dmem_we}, 0);
    check_eq("rst_be", {28'b0, mem_if.dmem_be}, 0);
    check_eq("rst_addr", mem_if.dmem_addr, 0);
    check_eq("rst_wdata", mem_if.dmem_wdata, 0);
    check_eq("rst_ldata", ldata_a, 0);
    rst = 1'b0;

    run_access("sw", 0, 1, W_WORD, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 0);
    run_access("sb", 0, 1, W_BYTE, 0, 32'h103, 32'h000000A5, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
    run_access("lb", 1, 0, W_BYTE, 0, 32'h102, 0, 32'h80FF1234, 0, 1, 0, 0, 32'hFFFFFFFF);
    run_access("lbu", 1, 0, W_BYTE, 1, 32'h102, 0, 32'h80FF1234, 0, 1, 0, 0, 32'h000000FF);
    run_access("lh", 1, 0, W_HALF, 0, 32'h102, 0, 32'h80001234, 0, 1, 0, 0, 32'hFFFF8000);
    run_access("lhu", 1, 0, W_HALF, 1, 32'h102, 0, 32'h80001234, 0, 1, 0, 0, 32'h00008000);
    run_access("lw_stall", 1, 0, W_WORD, 1, 32'h104, 0, 32'h12345678, 3, 2, 0, 0, 32'h12345678);
    run_access("sh", 0, 1, W_HALF, 0, 32'h102, 32'h1234ABCD, 0, 1, 0, 4'b1100, 32'hABCDABCD, 0);
    run_access("rw_both", 1, 1, W_WORD, 0, 32'h108, 32'hCAFEF00D, 0, 0, 0, 4'b1111, 32'hCAFEF00D, 0);
    run_access("lw_w11", 1, 0, 2'b11, 0, 32'h10C, 0, 32'h8765ABCD, 0, 2, 0, 0, 32'h8765ABCD);

`ifdef LSU_MISALIGN_TRAP_EN
    begin
      exp_t e;
      e.tag = "lw_misal"; e.addr = 0; e.be = 0; e.wdata = 0; e.we = 0; e.req = 0;
      e.ldata = 0; e.err = 0; e.misal = 1; e.lat = 1;
      model_ldata = 0;
      @(negedge clk); #1;
      mem_read = 1; mem_write = 0; mem_width = W_WORD; load_unsigned = 0; addr = 32'h101;
      start_a = 1; sb_q.push_back(e);
      start_cyc = cyc; grant_base = n_grant; base = done_cnt;
      for (int c = 0; c < 4 && done_cnt == base; c++) begin
        @(negedge clk); #1; start_a = 0;
        check_eq("lw_misal_noreq", {31'b0, mem_if.dmem_req}, 0);
      end
      check_eq("lw_misal_done_seen", done_cnt - base, 1);
    end
`else
    run_access("lw_unal", 1, 0, W_WORD, 0, 32'h101, 0, 32'h0BADF00D, 0, 1, 0, 0, 32'h0BADF00D);
`endif

    @(negedge clk); #1;
    mem_read = 0; mem_write = 0; start_a = 1;
    @(negedge clk); #1;
    start_a = 0;
    check_eq("nop_start_busy", {31'b0, busy_a}, 0);
    check_eq("nop_start_req", {31'b0, mem_if.dmem_req}, 0);

    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 2)); w = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1)); a = $urandom; sd = $urandom; rdv = $urandom;
      if (w == W_HALF) a[0] = 1'b0;
      else if (w[1]) a[1:0] = 2'b00;
      run_access("rnd", op != 2'd1, op != 2'd0, w, uns, a, sd, rdv,
                 $urandom_range(0, 2), $urandom_range(1, 3),
                 ref_be(w, a), ref_wdata(w, sd), ref_load(w, uns, a, rdv));
    end

    @(negedge clk); #1;
    mem_read = 1; mem_write = 0; mem_width = W_WORD; addr = 32'h200; start_b = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); #1;
      start_b = 0;
      if (c < 5) check_eq("tmo_req_held", {31'b0, tmo_if.dmem_req}, 1);
      if (c == 5) begin
        check_eq("tmo_done", {31'b0, done_b}, 1);
        check_eq("tmo_err", {31'b0, err_b}, 1);
        check_eq("tmo_ldata", ldata_b, 0);
        check_eq("tmo_req_drop", {31'b0, tmo_if.dmem_req}, 0);
      end else begin
        check_eq("tmo_no_done", {31'b0, done_b}, 0);
        check_eq("tmo_no_err", {31'b0, err_b}, 0);
      end
    end

    @(negedge clk); #1;
    mem_read = 1; mem_write = 0; mem_width = W_WORD; addr = 32'h300; start_a = 1;
    @(negedge clk); #1;
    start_a = 0; mem_if.dmem_gnt = 1;
    @(negedge clk); #1;
    mem_if.dmem_gnt = 0;
    check_eq("rstw_in_wait", {31'b0, busy_a}, 1);
    rst = 1;
    @(negedge clk); #1;
    rst = 0; model_ldata = 0;
    check_eq("rstw_busy", {31'b0, busy_a}, 0);
    check_eq("rstw_req", {31'b0, mem_if.dmem_req}, 0);
    check_eq("rstw_ldata", ldata_a, 0);
    mem_if.dmem_rvalid = 1; mem_if.dmem_rdata = 32'h55AA55AA;
    @(negedge clk); #1;
    mem_if.dmem_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      check_eq("rstw_late_rvalid_done", {31'b0, done_a}, 0);
      check_eq("rstw_late_rvalid_busy", {31'b0, busy_a}, 0);
      @(negedge clk); #1;
    end
    check_eq("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
